// File: rtl/bus_sync_tx_arbiter.sv
// Round-robin arbiter that shares one mux-recirculation synchronizer channel among N_REQ requesters.
// Optional acknowledge watchdog: define BUS_SYNC_ARB_TIMEOUT_EN to add the counter and the timeout_err port.
module bus_sync_tx_arbiter #(
   parameter int N_REQ          = 4,
   parameter int WIDTH          = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                   a_clk,
   input  logic                   reset_n,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]       gnt,
   output logic [WIDTH-1:0]       sync_data,
   output logic                   sync_ld_pls,
   input  logic                   b_ack_tgl,
   output logic                   busy
`ifdef BUS_SYNC_ARB_TIMEOUT_EN
   ,
   output logic                   timeout_err
`endif
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [PW:0]   N_REQ_W = (PW+1)'(N_REQ);
   localparam logic [PW-1:0] LAST    = PW'(N_REQ - 1);

   localparam logic [0:0] IDLE     = 1'b0;
   localparam logic [0:0] WAIT_ACK = 1'b1;

   generate
      if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n_req
         $error("bus_sync_tx_arbiter: N_REQ must be in 2..16");
      end
      if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
         $error("bus_sync_tx_arbiter: TIMEOUT_CYCLES must be at least 1");
      end
   endgenerate

   logic [0:0]    state;
   logic [PW-1:0] ptr;
   logic          ack_s1, ack_s2, ack_s3;
   logic          ack_evt;

   logic [PW-1:0] win;
   logic [PW:0]   cand;
   logic          found;

   // b_ack_tgl is asynchronous; only ack_s2 onward may be used by logic.
   always_ff @(posedge a_clk or negedge reset_n) begin
      if (!reset_n) begin
         ack_s1 <= 1'b0;
         ack_s2 <= 1'b0;
         ack_s3 <= 1'b0;
      end else begin
         ack_s1 <= b_ack_tgl;
         ack_s2 <= ack_s1;
         ack_s3 <= ack_s2;
      end
   end

   assign ack_evt = ack_s2 ^ ack_s3;

   // Scan upward from the pointer with wrap; the first set request wins.
   always_comb begin
      win   = '0;
      cand  = '0;
      found = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = {1'b0, ptr} + (PW+1)'(i);
         if (cand >= N_REQ_W)
            cand = cand - N_REQ_W;
         if (!found && req[cand[PW-1:0]]) begin
            found = 1'b1;
            win   = cand[PW-1:0];
         end
      end
   end

`ifdef BUS_SYNC_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);
   logic [CW-1:0] cnt;
`endif

   always_ff @(posedge a_clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         ptr         <= '0;
         gnt         <= '0;
         sync_data   <= '0;
         sync_ld_pls <= 1'b0;
`ifdef BUS_SYNC_ARB_TIMEOUT_EN
         cnt         <= '0;
         timeout_err <= 1'b0;
`endif
      end else begin
         gnt         <= '0;
         sync_ld_pls <= 1'b0;
         case (state)
            IDLE: begin
               // A stray ack_evt here is deliberately ignored.
               if (found) begin
                  sync_data   <= req_data[win*WIDTH +: WIDTH];
                  gnt         <= {{(N_REQ-1){1'b0}}, 1'b1} << win;
                  sync_ld_pls <= 1'b1;
                  ptr         <= (win == LAST) ? '0 : win + 1'b1;
                  state       <= WAIT_ACK;
`ifdef BUS_SYNC_ARB_TIMEOUT_EN
                  cnt         <= '0;
`endif
               end
            end
            WAIT_ACK: begin
`ifdef BUS_SYNC_ARB_TIMEOUT_EN
               cnt <= cnt + 1'b1;
               if (ack_evt) begin
                  state <= IDLE;
               end else if (cnt == T_LAST) begin
                  state       <= IDLE;
                  timeout_err <= 1'b1;
               end
`else
               if (ack_evt)
                  state <= IDLE;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state == WAIT_ACK);

endmodule

// File: tb/tb_bus_sync_tx_arbiter.sv
// Bench for bus_sync_tx_arbiter: directed requests, grant words checked by a queue-based scoreboard.
// Timeout checks are compiled in with BUS_SYNC_ARB_TIMEOUT_EN.
module tb_bus_sync_tx_arbiter;

   logic        a_clk = 1'b0;
   logic        reset_n;
   logic [3:0]  req;
   logic [15:0] req_data;
   logic [3:0]  gnt;
   logic [3:0]  sync_data;
   logic        sync_ld_pls;
   logic        b_ack_tgl;
   logic        busy;
`ifdef BUS_SYNC_ARB_TIMEOUT_EN
   logic        timeout_err;
`endif

   int checks   = 0;
   int failures = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mon_e;

   bus_sync_tx_arbiter #(
      .N_REQ(4),
      .WIDTH(4),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .a_clk(a_clk),
      .reset_n(reset_n),
      .req(req),
      .req_data(req_data),
      .gnt(gnt),
      .sync_data(sync_data),
      .sync_ld_pls(sync_ld_pls),
      .b_ack_tgl(b_ack_tgl),
      .busy(busy)
`ifdef BUS_SYNC_ARB_TIMEOUT_EN
      ,
      .timeout_err(timeout_err)
`endif
   );

   always #5 a_clk = ~a_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_grant(input logic [3:0] g, input logic [3:0] d);
      exp_q.push_back({g, d});
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge a_clk);
      #2;
   endtask

   task automatic wait_busy(input logic v, input int budget, input string name);
      for (int n = 0; n < budget; n++) begin
         @(negedge a_clk);
         if (busy === v) break;
      end
      check(name, {31'b0, busy}, {31'b0, v});
   endtask

   task automatic serve(input logic [3:0] req_after, input string name);
      wait_busy(1'b1, 20, name);
      cyc(1);
      req       = req_after;
      b_ack_tgl = ~b_ack_tgl;
      wait_busy(1'b0, 20, name);
   endtask

   // Monitor: every grant/load pulse must match the oldest expected word.
   always @(negedge a_clk) begin
      if (reset_n === 1'b1 && (sync_ld_pls !== 1'b0 || gnt !== 4'b0000)) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_grant: got gnt=%b data=%h ld=%b expected no grant",
                     gnt, sync_data, sync_ld_pls);
         end else begin
            mon_e = exp_q.pop_front();
            check("grant", {23'b0, sync_ld_pls, gnt, sync_data}, {23'b0, 1'b1, mon_e});
         end
      end
   end

   initial begin
      #500000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n   = 1'b0;
      req       = 4'b0000;
      req_data  = 16'hC3A1; // slice0=1 slice1=A slice2=3 slice3=C
      b_ack_tgl = 1'b0;

      repeat (3) @(negedge a_clk);
      check("rst_gnt", {28'b0, gnt}, 0);
      check("rst_ld", {31'b0, sync_ld_pls}, 0);
      check("rst_data", {28'b0, sync_data}, 0);
      check("rst_busy", {31'b0, busy}, 0);
`ifdef BUS_SYNC_ARB_TIMEOUT_EN
      check("rst_timeout_err", {31'b0, timeout_err}, 0);
`endif
      @(posedge a_clk);
      #2 reset_n = 1'b1;
      cyc(2);

      // Single request: grant one cycle after sampling, ack returns busy low after three edges.
      expect_grant(4'b0010, 4'hA);
      req = 4'b0010;
      @(posedge a_clk);
      @(negedge a_clk);
      check("single_busy", {31'b0, busy}, 1);
      cyc(1);
      req = 4'b0000;
      @(negedge a_clk);
      check("single_ld_one_cycle", {31'b0, sync_ld_pls}, 0);
      check("single_gnt_one_cycle", {28'b0, gnt}, 0);
      cyc(4);
      @(negedge a_clk);
      check("single_busy_hold", {31'b0, busy}, 1);
      cyc(1);
      b_ack_tgl = ~b_ack_tgl;
      @(posedge a_clk);
      @(negedge a_clk);
      check("ack_lat_m", {31'b0, busy}, 1);
      @(negedge a_clk);
      check("ack_lat_m1", {31'b0, busy}, 1);
      @(negedge a_clk);
      check("ack_lat_m2", {31'b0, busy}, 0);
      check("single_data_held", {28'b0, sync_data}, 32'hA);

      // Reset while waiting for acknowledge; b side is reset alongside.
      cyc(1);
      expect_grant(4'b0100, 4'h3);
      req = 4'b0100;
      wait_busy(1'b1, 10, "rst_mid_busy");
      cyc(1);
      req       = 4'b0000;
      reset_n   = 1'b0;
      b_ack_tgl = 1'b0;
      #1;
      check("rst_mid_gnt", {28'b0, gnt}, 0);
      check("rst_mid_ld", {31'b0, sync_ld_pls}, 0);
      check("rst_mid_data", {28'b0, sync_data}, 0);
      check("rst_mid_busy", {31'b0, busy}, 0);
      cyc(1);
      reset_n = 1'b1;

      // All requesting: pointer restarts at 0 after reset, order 0,1,2,3,0.
      cyc(1);
      expect_grant(4'b0001, 4'h1);
      expect_grant(4'b0010, 4'hA);
      expect_grant(4'b0100, 4'h3);
      expect_grant(4'b1000, 4'hC);
      expect_grant(4'b0001, 4'h1);
      req = 4'b1111;
      serve(4'b1111, "all_0");
      serve(4'b1111, "all_1");
      serve(4'b1111, "all_2");
      serve(4'b1111, "all_3");
      serve(4'b0000, "all_4");

      // Pointer wrap: move pointer to 3, then 3 and 0 request together.
      cyc(1);
      expect_grant(4'b0100, 4'h3);
      req = 4'b0100;
      serve(4'b0000, "wrap_pre");
      cyc(1);
      expect_grant(4'b1000, 4'hC);
      expect_grant(4'b0001, 4'h1);
      req = 4'b1001;
      serve(4'b1001, "wrap_3");
      serve(4'b0000, "wrap_0");

      // Spurious acknowledge in IDLE must not shorten the next transfer.
      cyc(1);
      b_ack_tgl = ~b_ack_tgl;
      cyc(6);
      @(negedge a_clk);
      check("spur_idle_busy", {31'b0, busy}, 0);
      cyc(1);
      expect_grant(4'b0001, 4'h1);
      req = 4'b0001;
      wait_busy(1'b1, 10, "spur_grant_busy");
      cyc(1);
      req = 4'b0000;
      for (int i = 0; i < 6; i++) begin
         @(negedge a_clk);
         check("spur_no_early_idle", {31'b0, busy}, 1);
      end
      cyc(1);
      b_ack_tgl = ~b_ack_tgl;
      wait_busy(1'b0, 20, "spur_own_ack");
`ifdef BUS_SYNC_ARB_TIMEOUT_EN
      check("pre_timeout_err", {31'b0, timeout_err}, 0);

      // No acknowledge: watchdog releases the bus and latches the error.
      cyc(1);
      expect_grant(4'b0010, 4'hA);
      req = 4'b0010;
      wait_busy(1'b1, 10, "to_grant_busy");
      cyc(1);
      req = 4'b0000;
      wait_busy(1'b0, 9, "to_idle");
      check("to_err_set", {31'b0, timeout_err}, 1);
      cyc(1);
      b_ack_tgl = ~b_ack_tgl;
      cyc(6);
      @(negedge a_clk);
      check("to_late_ack_busy", {31'b0, busy}, 0);
      check("to_err_sticky", {31'b0, timeout_err}, 1);
`endif

      cyc(3);
      check("queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
